// File: rtl/load_writeback_if.sv
// Bundle between the writeback stage and its neighbours: execute-side issue,
// data-memory read handshake and register-file write port.
interface load_writeback_if;
    logic        start;
    logic        is_load;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [4:0]  wd_reg;
    logic [31:0] rdv;
    logic        wren;
    logic        done;
    logic        err;

    modport slave (
        input  start, is_load, funct3, rd, alu_result, mem_ready, mem_rdata,
        output busy, mem_req, mem_addr, wd_reg, rdv, wren, done, err
    );

    modport master (
        output start, is_load, funct3, rd, alu_result, mem_ready, mem_rdata,
        input  busy, mem_req, mem_addr, wd_reg, rdv, wren, done, err
    );
endinterface

// File: rtl/load_writeback.sv
// Writeback stage: forwards ALU results or runs one data-memory load with
// byte/half/word extension, then issues a single register-file write.
module load_writeback #(
    parameter int TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst_n,
    load_writeback_if.slave bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [4:0]  wd_reg_q, wd_reg_d;
    logic [31:0] rdv_q, rdv_d;
    logic        wren_q, wren_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        bad_load;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] load_ext;

    // Illegal encodings and misaligned accesses retire immediately with err.
    always_comb begin
        bad_load = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: bad_load = 1'b0;
            3'b001, 3'b101: bad_load = bus.alu_result[0];
            3'b010:         bad_load = (bus.alu_result[1:0] != 2'b00);
            default:        bad_load = 1'b1;
        endcase
    end

    always_comb begin
        byte_sh  = bus.mem_rdata >> {addr_lo_q, 3'b000};
        half_sh  = bus.mem_rdata >> {addr_lo_q[1], 4'b0000};
        load_ext = bus.mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  load_ext = {24'h000000, byte_sh[7:0]};
            3'b001:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  load_ext = {16'h0000, half_sh[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wd_reg_d   = wd_reg_q;
        rdv_d      = rdv_q;
        wren_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    funct3_d  = bus.funct3;
                    addr_lo_d = bus.alu_result[1:0];
                    wd_reg_d  = bus.rd;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    if (!bus.is_load) begin
                        rdv_d   = bus.alu_result;
                        wren_d  = (bus.rd != 5'd0);
                        done_d  = 1'b1;
                        state_d = WRITE;
                    end else if (bad_load) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = WRITE;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.alu_result[31:2], 2'b00};
                        state_d    = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // ready on the final count still completes the load
                if (bus.mem_ready) begin
                    rdv_d     = load_ext;
                    wren_d    = (wd_reg_q != 5'd0);
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            wd_reg_q   <= 5'd0;
            rdv_q      <= 32'h0;
            wren_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wd_reg_q   <= wd_reg_d;
            rdv_q      <= rdv_d;
            wren_q     <= wren_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.wd_reg   = wd_reg_q;
    assign bus.rdv      = rdv_q;
    assign bus.wren     = wren_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_load_writeback.sv
// Scoreboard bench for load_writeback: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_load_writeback;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdv;
        logic        wren;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    load_writeback_if bus ();

    load_writeback #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("wd_reg", {27'd0, bus.wd_reg}, {27'd0, e.rd});
                    chk("wren", {31'd0, bus.wren}, {31'd0, e.wren});
                    chk("err", {31'd0, bus.err}, {31'd0, e.err});
                    if (e.wren) chk("rdv", bus.rdv, e.rdv);
                end
            end else if (rst_n === 1'b1 && bus.wren === 1'b1) begin
                total++;
                bad++;
                $display("FAIL stray_wren actual=1 required=0");
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_start", {31'd0, bus.busy}, 32'd0);
    endtask

    // dly < 0: memory never answers.
    task automatic txn(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] eaddr,
                       input logic [31:0] rdata, input int dly,
                       input logic [31:0] erdv, input logic ewren, input logic eerr,
                       input logic ereq);
        int n;
        wait_idle();
        bus.start      = 1'b1;
        bus.is_load    = ld;
        bus.funct3     = f3;
        bus.rd         = rd;
        bus.alu_result = addr;
        exp_q.push_back('{rd: rd, rdv: erdv, wren: ewren, err: eerr});
        @(negedge clk);
        bus.start = 1'b0;
        chk("mem_req_rise", {31'd0, bus.mem_req}, {31'd0, ereq});
        if (ereq) begin
            chk("mem_addr", bus.mem_addr, eaddr);
            if (dly < 0) begin
                n = 0;
                while (bus.mem_req === 1'b1 && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk("timeout_cycles", n, 32'd16);
            end else begin
                repeat (dly) @(negedge clk);
                chk("mem_req_held", {31'd0, bus.mem_req}, 32'd1);
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rdata;
                @(negedge clk);
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'h0;
                chk("mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
            end
        end else begin
            chk("done_one_cycle", {31'd0, bus.done}, 32'd1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.is_load = 1'b0; bus.funct3 = 3'b000; bus.rd = 5'd0;
        bus.alu_result = 32'h0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_rdv", bus.rdv, 32'd0);
        chk("rst_wd_reg", {27'd0, bus.wd_reg}, 32'd0);
        chk("rst_flags", {29'd0, bus.wren, bus.done, bus.err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU forward, then rdv holds after the write cycle
        txn(1'b0, 3'b000, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rdv_hold", bus.rdv, 32'hDEADBEEF);
        chk("busy_clear", {31'd0, bus.busy}, 32'd0);
        // back-to-back ALU, and x0 suppressed
        txn(1'b0, 3'b000, 5'd0, 32'h12345678, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        // loads
        txn(1'b1, 3'b000, 5'd1, 32'h1003, 32'h1000, 32'h80FF0000, 3, 32'hFFFFFF80, 1'b1, 1'b0, 1'b1);
        txn(1'b1, 3'b101, 5'd2, 32'h2002, 32'h2000, 32'hABCD1234, 1, 32'h0000ABCD, 1'b1, 1'b0, 1'b1);
        txn(1'b1, 3'b001, 5'd3, 32'h2002, 32'h2000, 32'hABCD1234, 0, 32'hFFFFABCD, 1'b1, 1'b0, 1'b1);
        txn(1'b1, 3'b100, 5'd4, 32'h1001, 32'h1000, 32'h123456F0, 2, 32'h00000056, 1'b1, 1'b0, 1'b1);
        txn(1'b1, 3'b000, 5'd6, 32'h1000, 32'h1000, 32'h000000F0, 0, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b1);
        txn(1'b1, 3'b001, 5'd7, 32'h1000, 32'h1000, 32'h00008001, 1, 32'hFFFF8001, 1'b1, 1'b0, 1'b1);
        txn(1'b1, 3'b010, 5'd8, 32'h4000, 32'h4000, 32'hCAFEF00D, 15, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1);
        txn(1'b1, 3'b010, 5'd0, 32'h6004, 32'h6004, 32'h55555555, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        // errors: misaligned and illegal funct3
        txn(1'b1, 3'b010, 5'd9, 32'h3001, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
        txn(1'b1, 3'b001, 5'd10, 32'h1001, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
        txn(1'b1, 3'b011, 5'd11, 32'h1000, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
        txn(1'b1, 3'b110, 5'd12, 32'h1000, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
        // timeout
        txn(1'b1, 3'b010, 5'd13, 32'h5000, 32'h5000, 32'h0, -1, 32'h0, 1'b0, 1'b1, 1'b1);

        // mem_ready while idle is ignored
        wait_idle();
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready_no_req", {31'd0, bus.mem_req}, 32'd0);
        chk("idle_ready_no_busy", {31'd0, bus.busy}, 32'd0);
        bus.mem_ready = 1'b0;

        // start while busy dropped, then reset mid-load
        wait_idle();
        bus.start = 1'b1; bus.is_load = 1'b1; bus.funct3 = 3'b010;
        bus.rd = 5'd14; bus.alu_result = 32'h7000;
        @(negedge clk);
        bus.is_load = 1'b0; bus.rd = 5'd15; bus.alu_result = 32'h11111111;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_start_ignored_req", {31'd0, bus.mem_req}, 32'd1);
        chk("busy_start_ignored_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_done_wren", {30'd0, bus.done, bus.wren}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'd0, bus.busy, bus.mem_req}, 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
